gbus_burst_sched: RTL and testbench
===================================

# gbus_burst_sched

Round-robin burst scheduler for the global bus (gbus). It arbitrates among `NUM_REQ` requesters and holds the grant for the winner's full burst of beats. Priority rotates one-hot after every grant, so requesters are served in a fair rotation. It sits between the core-side request ports and the gbus datapath, and drives the one-hot grant that steers the gbus mux.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be ≥ 2.
- `LEN_W`, default 8: width of each burst-length field.
- `FIRST_PRI`, default `'b1`: one-hot priority vector loaded at reset.
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `req`, input, `NUM_REQ`: per-requester burst request, level-sensitive.
- `req_len`, input, `NUM_REQ*LEN_W`: per-requester burst length minus 1. Requester i uses bits `[i*LEN_W +: LEN_W]`.
- `bus_ready`, input, 1: gbus accepts a beat this cycle.
- `gnt`, output, `NUM_REQ`: registered one-hot grant; all zeros when idle.
- `owner_id`, output, `$clog2(NUM_REQ)`: binary index of the current grant holder; 0 when idle.
- `beat_fire`, output, 1: `|gnt & bus_ready`, a beat is transferred this cycle.
- `last_beat`, output, 1: `beat_fire` on the final beat of the burst.
- `busy`, output, 1: the FSM is in BUSY.

## Operation
- The FSM has two states, IDLE and BUSY.
- In IDLE with `|req = 0`, the FSM stays in IDLE and `gnt = 0`.
- In IDLE with `|req = 1`, the winner is the first set `req` bit at or cyclically left of the one-hot `pri`.
  - Registered effects at the clock edge: `gnt` = winner one-hot, `owner_id` = winner index, `beat_cnt` = winner's `req_len`, `pri` = `gnt` rotated left by 1 (index `NUM_REQ-1` wraps to 0).
  - The FSM moves to BUSY.
- In BUSY:
  - Each cycle with `bus_ready = 1` is a beat.
  - If `beat_cnt != 0`, `beat_cnt` decrements by 1.
  - If `beat_cnt == 0`, `last_beat = 1` and the FSM returns to IDLE, clearing `gnt` and `owner_id`.
  - While `bus_ready = 0`, state, counter and grant all hold.
- The `req_len` encoding is beats-minus-1. Value 0 is a 1-beat burst; all ones is a `2^LEN_W`-beat burst. No other width or wrap rules apply.
- `req` and `req_len` are sampled only in IDLE. Deasserting `req` or changing `req_len` during BUSY does not shorten or abort the burst; the owner must keep driving data until `last_beat`.
- `pri` is updated only on a grant, never on idle cycles. A requester that holds `req` therefore waits at most `NUM_REQ-1` bursts.
- Reset mid-burst: `gnt`, `owner_id`, `beat_cnt`, `busy` and `state` clear to 0 and IDLE immediately (asynchronous), and `pri` reloads to `FIRST_PRI`. The in-flight burst is discarded with no `last_beat`.

## Timing
- Reset values: `gnt = 0`, `owner_id = 0`, `busy = 0`, `beat_fire = 0`, `last_beat = 0`, `pri = FIRST_PRI`, `beat_cnt = 0`.
- Request-to-grant latency is 1 cycle: `req` seen in IDLE at edge n gives `gnt` valid from edge n+1.
- A burst of L+1 beats with `bus_ready` held at 1 keeps `gnt` high for exactly L+1 cycles.
- Bursts are separated by one idle cycle: the IDLE cycle after `last_beat` arbitrates, and the next `gnt` appears one cycle later. Peak bus occupancy is therefore (L+1)/(L+2).
- `beat_fire` and `last_beat` are combinational from registered `gnt`/`state`/`beat_cnt` and `bus_ready`; there is no path from `req` to them.
- Simultaneous requests are resolved only by `pri`. A new `req` arriving while BUSY waits for IDLE.

## Test plan
- Single beat: with `FIRST_PRI = 4'b0001`, assert `req = 4'b0100` with `len2 = 0` and `bus_ready = 1`.
  - Required: `gnt = 4'b0100` for 1 cycle, `owner_id = 2`, `last_beat` coincident with the grant, then `gnt = 0`.
  - Required: `pri` becomes `4'b1000`.
- Rotation: `req = 4'b1111` held, all lengths 0, `bus_ready = 1`.
  - Required: grant order 0, 1, 2, 3, 0 with one idle cycle between grants.
- Wrap and stall: `req = 4'b1001` with `pri = 4'b1000` and `len3 = 3`; toggle `bus_ready` 1,0,1,0,1,1.
  - Required: `gnt = 4'b1000` for 6 cycles and 4 `beat_fire` pulses, with `last_beat` on the sixth cycle.
  - Required: next grant goes to requester 0.
- Request withdrawal: requester 1 with `len = 7` drops `req` after 2 beats.
  - Required: `gnt` persists until 8 beats complete and `busy` deasserts after `last_beat`.
- Max length: `len = 8'hFF`.
  - Required: exactly 256 `beat_fire` pulses, then IDLE.
- Reset mid-burst: pulse `rst_n` low on beat 3 of 5.
  - Required: `gnt`, `busy` and `owner_id` go to 0 asynchronously, no `last_beat`, `pri = FIRST_PRI`.
  - Required: after release, `req = 4'b0011` grants requester 0.

Source files
------------

// File: rtl/gbus_burst_sched.sv
// Round-robin burst scheduler for the global bus: grants one requester at a time
// and holds the one-hot grant for the winner's whole burst of beats.
module gbus_burst_sched #(
  parameter int                 NUM_REQ   = 4,
  parameter int                 LEN_W     = 8,
  parameter logic [NUM_REQ-1:0] FIRST_PRI = 'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  input  logic                       bus_ready,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] owner_id,
  output logic                       beat_fire,
  output logic                       last_beat,
  output logic                       busy
);
  // state | meaning
  // IDLE  | no grant held; arbitrate among req starting at pri
  // BUSY  | grant held; beat_cnt counts beats down to last_beat

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [2*NUM_REQ-1:0] ONE2 = {{(2*NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state, state_d;
  logic [NUM_REQ-1:0] pri, pri_d, gnt_d, win;
  logic [ID_W-1:0]    owner_d, win_id;
  logic [LEN_W-1:0]   beat_cnt, cnt_d, win_len;
  logic [2*NUM_REQ-1:0] dbl_req, dbl_low;

  // Doubled request vector lets the search from pri wrap past the top index;
  // the lowest set bit at or above pri is the winner.
  assign dbl_req = {req, req} & ~({{NUM_REQ{1'b0}}, pri} - ONE2);
  assign dbl_low = dbl_req & ~(dbl_req - ONE2);
  assign win     = dbl_low[NUM_REQ-1:0] | dbl_low[2*NUM_REQ-1:NUM_REQ];

  always_comb begin
    win_id  = '0;
    win_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        win_id  = ID_W'(i);
        win_len = req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    owner_d = owner_id;
    cnt_d   = beat_cnt;
    pri_d   = pri;
    case (state)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          gnt_d   = win;
          owner_d = win_id;
          cnt_d   = win_len;
          pri_d   = {win[NUM_REQ-2:0], win[NUM_REQ-1]};
        end
      end
      BUSY: begin
        if (bus_ready) begin
          if (beat_cnt == '0) begin
            state_d = IDLE;
            gnt_d   = '0;
            owner_d = '0;
          end else begin
            cnt_d = beat_cnt - LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      owner_id <= '0;
      beat_cnt <= '0;
      pri      <= FIRST_PRI;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      owner_id <= owner_d;
      beat_cnt <= cnt_d;
      pri      <= pri_d;
    end
  end

  assign busy      = (state == BUSY);
  assign beat_fire = (|gnt) & bus_ready;
  assign last_beat = beat_fire & busy & (beat_cnt == '0);

endmodule

// File: tb/tb_gbus_burst_sched.sv
// Self-checking bench for gbus_burst_sched: expected bursts are queued when
// requests are driven and compared when the grant completes its last beat.
module tb_gbus_burst_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_len;
  logic        bus_ready;
  logic [3:0]  gnt;
  logic [1:0]  owner_id;
  logic        beat_fire, last_beat, busy;

  gbus_burst_sched #(.NUM_REQ(4), .LEN_W(8), .FIRST_PRI(4'b0001)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .bus_ready(bus_ready),
    .gnt(gnt), .owner_id(owner_id), .beat_fire(beat_fire), .last_beat(last_beat),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int owner; int beats; int cycles; } exp_t;
  exp_t sb[$];
  int   starts[$];
  int   n_chk = 0, n_err = 0;
  int   cyc = 0, grant_cnt = 0;
  int   n_beats, n_cyc;
  logic in_burst = 1'b0, prev_last = 1'b0;
  logic [3:0] cur_gnt;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Burst monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      in_burst  = 1'b0;
      prev_last = 1'b0;
    end else begin
      if (prev_last) begin
        check("gap_gnt", int'(gnt), 0);
        check("gap_busy", int'(busy), 0);
      end
      prev_last = 1'b0;
      if (|gnt) begin
        if (!in_burst) begin
          in_burst = 1'b1;
          cur_gnt  = gnt;
          n_beats  = 0;
          n_cyc    = 0;
          grant_cnt++;
          starts.push_back(cyc);
          check("busy_on", int'(busy), 1);
        end
        check("gnt_hold", int'(gnt), int'(cur_gnt));
        n_cyc++;
        if (beat_fire) n_beats++;
        if (last_beat) begin
          check("lb_fire", int'(beat_fire), 1);
          check("sb_pending", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("owner", int'(owner_id), e.owner);
            check("gnt_val", int'(cur_gnt), 1 << e.owner);
            check("beats", n_beats, e.beats);
            check("cycles", n_cyc, e.cycles);
          end
          in_burst  = 1'b0;
          prev_last = 1'b1;
        end
      end else begin
        check("gnt_drop", int'(in_burst), 0);
        check("idle_lb", int'(last_beat), 0);
      end
    end
  end

  task automatic push(input int owner, input int beats, input int cycles);
    exp_t e;
    e.owner = owner; e.beats = beats; e.cycles = cycles;
    sb.push_back(e);
  endtask

  task automatic wait_grants(input int target, input int budget);
    int n = 0;
    while (grant_cnt < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check("grant_to", int'(grant_cnt >= target), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || (|gnt)) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check("idle_to", int'(busy || (|gnt)), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pat;
    int g0, s;
    rst_n = 1'b0; req = '0; req_len = '0; bus_ready = 1'b1;
    #12;
    check("rst_gnt", int'(gnt), 0);
    check("rst_owner", int'(owner_id), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fire", int'(beat_fire), 0);
    check("rst_lb", int'(last_beat), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Rotation from reset priority: 0,1,2,3,0 with one idle cycle between grants.
    for (int i = 0; i < 5; i++) push(i % 4, 1, 1);
    g0 = grant_cnt;
    req = 4'b1111; req_len = '0;
    wait_grants(g0 + 5, 40);
    req = '0;
    s = starts.size();
    for (int i = 1; i < 5; i++) check("rot_gap", starts[s-5+i] - starts[s-6+i], 2);
    wait_idle(10);

    // Single beat on requester 2: granted next cycle, last_beat with the grant.
    push(2, 1, 1);
    g0 = grant_cnt;
    req = 4'b0100; req_len = '0;
    @(posedge clk); #1;
    check("sb_lat", int'(gnt), 4);
    check("sb_last", int'(last_beat), 1);
    wait_grants(g0 + 1, 5);
    req = '0;
    wait_idle(10);

    // Wrap and stall: pri now points at 3; 4-beat burst with bus_ready gaps.
    push(3, 4, 6);
    push(0, 1, 1);
    g0 = grant_cnt;
    pat = 6'b110101;
    req = 4'b1001; req_len = {8'd3, 8'd0, 8'd0, 8'd0};
    @(posedge clk); #1;
    check("wrap_lat", int'(gnt), 8);
    for (int k = 0; k < 6; k++) begin
      bus_ready = pat[k];
      @(posedge clk); #1;
    end
    bus_ready = 1'b1;
    wait_grants(g0 + 2, 10);
    req = '0;
    wait_idle(10);

    // Withdrawal: requester 1, 8 beats, req and length change after 2 beats.
    push(1, 8, 8);
    req = 4'b0010; req_len = {8'd0, 8'd0, 8'd7, 8'd0};
    repeat (3) @(posedge clk);
    #1;
    check("wd_busy", int'(busy), 1);
    req = '0; req_len = '0;
    wait_idle(20);

    // Maximum length on requester 2.
    push(2, 256, 256);
    g0 = grant_cnt;
    req = 4'b0100; req_len = {8'd0, 8'hFF, 8'd0, 8'd0};
    wait_grants(g0 + 1, 5);
    req = '0;
    wait_idle(300);

    // Reset during beat 3 of a 5-beat burst on requester 0.
    req = 4'b0001; req_len = {8'd0, 8'd0, 8'd0, 8'd4};
    repeat (3) @(posedge clk);
    #2;
    check("mid_busy", int'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_gnt", int'(gnt), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_owner", int'(owner_id), 0);
    check("arst_lb", int'(last_beat), 0);
    #3;
    push(0, 1, 1);
    g0 = grant_cnt;
    req = 4'b0011; req_len = '0;
    rst_n = 1'b1;
    wait_grants(g0 + 1, 5);
    req = '0;
    wait_idle(10);

    repeat (3) @(posedge clk);
    check("sb_left", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
